fpu_divs_iter: RTL

// Iterative single-precision divider for the 33-bit internal FP format (res = A / B); the inverse
// of the pipelined single-precision multiplier. Format: [32] exp MSB, [31] sign, [30:23] exp low,
// [22:0] fraction; 9-bit exponent, bias 9'hff. exp 0 = zero, 9'h1fe = infinity, 9'h1ff = NaN.

---
 rtl/fpu_divs_iter_if.sv | 22 ++
 rtl/fpu_divs_iter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_divs_iter_if.sv
// Handshake/operand bundle for the iterative single-precision divider.
interface fpu_divs_iter_if;
  logic        start;
  logic [32:0] A;
  logic [32:0] B;
  logic [2:0]  rmode;
  logic [31:0] fpcsr;
  logic        busy;
  logic        done;
  logic [32:0] res;
  logic [10:0] raise;

  modport master (
    output start, A, B, rmode, fpcsr,
    input  busy, done, res, raise
  );

  modport slave (
    input  start, A, B, rmode, fpcsr,
    output busy, done, res, raise
  );
endinterface

// File: rtl/fpu_divs_iter.sv
// Iterative single-precision divider (res = A / B) for the 33-bit internal FP
// format: [32] exp MSB, [31] sign, [30:23] exp low, [22:0] fraction, bias 9'hff.
// Restoring radix-2, one quotient bit per cycle, start/busy/done handshake.
//
// fpcsr bits used : 0 clip_IEEE, 1 daz, 2 inv_flag
// raise bits      : 0 inv_excpt, 1 over_excpt, 2 under_excpt, 3 inexact_excpt,
//                   4 denor_consume, 5 denor_produce, 6 over_ieee,
//                   7 under_ieee, 8 inexact_ieee, 9 denor_ieee, 10 reserved
module fpu_divs_iter #(
  parameter int unsigned QBITS = 26
) (
  input logic            clk,
  input logic            rst,
  fpu_divs_iter_if.slave bus
);
  localparam int unsigned CSR_CLIP = 0;
  localparam int unsigned CSR_DAZ  = 1;
  localparam int unsigned CSR_INV  = 2;

  localparam int unsigned RS_INV          = 0;
  localparam int unsigned RS_OVER         = 1;
  localparam int unsigned RS_UNDER        = 2;
  localparam int unsigned RS_INEXACT      = 3;
  localparam int unsigned RS_OVER_IEEE    = 6;
  localparam int unsigned RS_UNDER_IEEE   = 7;
  localparam int unsigned RS_INEXACT_IEEE = 8;
  localparam int unsigned RS_DENOR_IEEE   = 9;

  localparam int unsigned CW = $clog2(QBITS);

  typedef enum logic [2:0] {IDLE, PREP, ITER, RND, FIN} state_t;

  state_t          state;
  logic            a_sign, b_sign;
  logic [8:0]      a_exp, b_exp;
  logic [2:0]      rmode_r;
  logic            clip_r, daz_r, inv_r;
  logic [10:0]     exp_r;
  logic [25:0]     rem;
  logic [23:0]     mb;
  logic [QBITS-1:0] q;
  logic [CW-1:0]   cnt;
  logic            busy_r, done_r;
  logic [32:0]     res_r;
  logic [10:0]     raise_r;

  logic            sign;
  logic            a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  logic            sp_hit;
  logic [32:0]     sp_res;
  logic [10:0]     sp_raise;
  logic [25:0]     rem_sub, rem_next;
  logic            q_bit;
  logic [22:0]     frac_t, frac_r;
  logic            rnd, stk, inc, lossy;
  logic [23:0]     sum;
  logic [10:0]     e0, e1;
  logic [8:0]      limit;
  logic [32:0]     rn_res;
  logic [10:0]     rn_raise;
  logic            unused_csr;

  assign unused_csr = ^bus.fpcsr[31:3];

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.res   = res_r;
  assign bus.raise = raise_r;

  assign sign   = a_sign ^ b_sign;
  assign a_nan  = (a_exp == 9'h1ff);
  assign a_inf  = (a_exp == 9'h1fe);
  assign a_zero = (a_exp == 9'h000);
  assign b_nan  = (b_exp == 9'h1ff);
  assign b_inf  = (b_exp == 9'h1fe);
  assign b_zero = (b_exp == 9'h000);

  // One restoring step: subtract divisor when it fits, that decides the quotient bit.
  assign rem_sub  = rem - {2'b00, mb};
  assign q_bit    = (rem >= {2'b00, mb});
  assign rem_next = q_bit ? rem_sub : rem;

  // Special-operand results, decided in PREP from the captured exponents.
  always_comb begin
    sp_hit   = 1'b1;
    sp_res   = '0;
    sp_raise = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      if (inv_r) begin
        sp_res           = {10'h3ff, 23'h000001};
        sp_raise[RS_INV] = 1'b1;
      end else begin
        sp_res = {10'h3ff, 23'h400001};
      end
    end else if (a_zero || b_inf) begin
      sp_res = {1'b0, sign, 31'd0};
    end else if (a_inf || b_zero) begin
      sp_res = {1'b1, sign, 8'hfe, 23'd0};
    end else begin
      sp_hit = 1'b0;
    end
  end

  // Normalise, round and range-limit the finished quotient.
  always_comb begin
    if (q[QBITS-1]) begin
      frac_t = q[24:2];
      rnd    = q[1];
      stk    = q[0] | (|rem);
      e0     = exp_r;
    end else begin
      frac_t = q[23:1];
      rnd    = q[0];
      stk    = |rem;
      e0     = exp_r - 11'd1;
    end
    case (rmode_r)
      3'd1:    inc = rnd;
      3'd2:    inc = rnd & (stk | frac_t[0]);
      3'd3:    inc = ~sign & rnd;
      3'd4:    inc = sign & rnd;
      3'd5:    inc = ~sign & (rnd | stk);
      3'd6:    inc = sign & (rnd | stk);
      default: inc = 1'b0;
    endcase
    sum = {1'b0, frac_t} + {23'd0, inc};
    if (sum[23]) begin
      frac_r = '0;
      e1     = e0 + 11'd1;
    end else begin
      frac_r = sum[22:0];
      e1     = e0;
    end
    limit    = clip_r ? 9'h17f : 9'h1fe;
    lossy    = rnd | stk;
    rn_res   = {e1[8], sign, e1[7:0], frac_r};
    rn_raise = '0;
    // Exponent is carried in 11 bits so huge quotients are never mistaken for negative ones.
    if (e1[10] || (e1 == 11'd0) || (daz_r && (e1 < 11'h081))) begin
      rn_res = {1'b0, sign, 31'd0};
      lossy  = 1'b1;
    end else if (e1 >= {2'b00, limit}) begin
      rn_res = {limit[8], sign, limit[7:0], 23'd0};
      lossy  = 1'b1;
      if (clip_r) begin
        rn_raise[RS_OVER_IEEE]  = ~sign;
        rn_raise[RS_UNDER_IEEE] = sign;
      end else begin
        rn_raise[RS_OVER]  = ~sign;
        rn_raise[RS_UNDER] = sign;
      end
    end else if (e1 < 11'h081) begin
      rn_raise[RS_DENOR_IEEE] = 1'b1;
    end
    rn_raise[RS_INEXACT]      = lossy;
    rn_raise[RS_INEXACT_IEEE] = lossy;
  end

  // Control FSM with registered handshake outputs and the divide datapath.
  // The first quotient bit is resolved in PREP (operands are already latched),
  // so ITER only runs QBITS-1 cycles and done lands 28 cycles after start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      res_r   <= '0;
      raise_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sign  <= bus.A[31];
            a_exp   <= {bus.A[32], bus.A[30:23]};
            b_sign  <= bus.B[31];
            b_exp   <= {bus.B[32], bus.B[30:23]};
            rem     <= {2'b00, 1'b1, bus.A[22:0]};
            mb      <= {1'b1, bus.B[22:0]};
            rmode_r <= bus.rmode;
            clip_r  <= bus.fpcsr[CSR_CLIP];
            daz_r   <= bus.fpcsr[CSR_DAZ];
            inv_r   <= bus.fpcsr[CSR_INV];
            q       <= '0;
            cnt     <= CW'(QBITS - 1);
            busy_r  <= 1'b1;
            state   <= PREP;
          end
        end
        PREP: begin
          exp_r <= {2'b00, a_exp} - {2'b00, b_exp} + 11'h0ff;
          if (sp_hit) begin
            res_r   <= sp_res;
            raise_r <= sp_raise;
            done_r  <= 1'b1;
            state   <= FIN;
          end else begin
            q     <= {q[QBITS-2:0], q_bit};
            rem   <= rem_next << 1;
            cnt   <= cnt - 1'b1;
            state <= ITER;
          end
        end
        ITER: begin
          q   <= {q[QBITS-2:0], q_bit};
          rem <= rem_next << 1;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= RND;
        end
        RND: begin
          res_r   <= rn_res;
          raise_r <= rn_raise;
          done_r  <= 1'b1;
          state   <= FIN;
        end
        FIN: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
